// File: rtl/ac_store_unit_if.sv
// Store request and memory write-bus bundle for ac_store_unit; master drives requests and ack, slave drives the bus.
// Valid-level signals only: no backpressure beyond mem_ack holding the write strobe.
interface ac_store_unit_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
);
   logic              st_req;
   logic [ADDR_W-1:0] st_addr;
   logic [DATA_W-1:0] ac_in;
   logic              mem_ack;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_data;
   logic              bus_oe;
   logic              bus_we;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output st_req, st_addr, ac_in, mem_ack,
      input  bus_addr, bus_data, bus_oe, bus_we, busy, done, err
   );

   modport slave (
      input  st_req, st_addr, ac_in, mem_ack,
      output bus_addr, bus_data, bus_oe, bus_we, busy, done, err
   );
endinterface

// File: rtl/ac_store_unit.sv
// Accumulator write-back: setup/strobe/hold write of captured AC payload; request-to-done 3 cycles + ack wait states.
// Requests outside IDLE are dropped; WRITE stalls on mem_ack (aborts after TIMEOUT cycles when STORE_TIMEOUT_EN is defined).
module ac_store_unit #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 5,
   parameter int PAYLOAD_W = 5,
   parameter int TIMEOUT   = 15
) (
   input logic           i_clk,
   input logic           i_rst,
   ac_store_unit_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WRITE, S_HOLD} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_oe;
   logic              r_we;
   logic              r_busy;
   logic              r_done;
   logic              w_unused;

`ifdef STORE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_err;
   assign w_unused = ^bus.ac_in[DATA_W-1:PAYLOAD_W];
`else
   assign w_unused = ^{bus.ac_in[DATA_W-1:PAYLOAD_W], (TIMEOUT > 0)};
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_data  <= '0;
         r_oe    <= 1'b0;
         r_we    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef STORE_TIMEOUT_EN
         r_cnt   <= '0;
         r_err   <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
`ifdef STORE_TIMEOUT_EN
         r_err  <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (bus.st_req) begin
                  r_addr  <= bus.st_addr;
                  r_data  <= DATA_W'(bus.ac_in[PAYLOAD_W-1:0]);
                  r_oe    <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_we    <= 1'b1;
               r_state <= S_WRITE;
`ifdef STORE_TIMEOUT_EN
               r_cnt   <= '0;
`endif
            end
            S_WRITE: begin
               // ack on the expiry cycle still completes normally
               if (bus.mem_ack) begin
                  r_we    <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_HOLD;
               end
`ifdef STORE_TIMEOUT_EN
               else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                  r_we    <= 1'b0;
                  r_oe    <= 1'b0;
                  r_busy  <= 1'b0;
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt   <= r_cnt + CNT_W'(1);
               end
`endif
            end
            S_HOLD: begin
               r_oe    <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.bus_addr = r_addr;
   assign bus.bus_data = r_data;
   assign bus.bus_oe   = r_oe;
   assign bus.bus_we   = r_we;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
`ifdef STORE_TIMEOUT_EN
   assign bus.err      = r_err;
`else
   assign bus.err      = 1'b0;
`endif
endmodule
